// File: rtl/cg_pkg.sv
// Shared definitions for the clock-gating enable path: FSM state encoding
// and the default idle run length used by the enable controller.
package cg_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    SLEEP  = 2'd2
  } cg_state_e;

  localparam int CG_IDLE_CYCLES_DEF = 4;
  localparam int CG_CNT_W_DEF       = 8;

  // The gated clock runs in every state except SLEEP.
  function automatic logic cg_clock_on(input cg_state_e s);
    return (s != SLEEP);
  endfunction

endpackage

// File: rtl/cg_change_det.sv
// Activity detector: registers the watched bus and flags any difference
// between the current value and the value captured on the previous edge.
module cg_change_det #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_chg
);

  logic [WIDTH-1:0] r_d_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_prev <= '0;
    end else begin
      r_d_prev <= i_d;
    end
  end

  assign o_chg = (i_d != r_d_prev);

endmodule

// File: rtl/cg_enable_ctrl.sv
// Activity-based enable for an integrated clock-gating cell: keeps the gated
// clock running while data moves, drains one cycle, then gates off when idle.
module cg_enable_ctrl
  import cg_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int IDLE_CYCLES = CG_IDLE_CYCLES_DEF,
  parameter int CNT_W       = CG_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             force_on,
  input  logic             sleep_req,
  output logic             gate_en,
  output logic             awake,
  output logic             wake_pulse,
  output logic [CNT_W-1:0] idle_cnt
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

  cg_state_e        r_state;
  cg_state_e        w_state_next;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0] w_idle_cnt_next;
  logic             r_gate_en;
  logic             r_awake;
  logic             r_wake_pulse;
  logic             w_wake_next;
  logic             w_chg;
  logic             w_activity;

  cg_change_det #(
    .WIDTH (WIDTH)
  ) u_change_det (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (d),
    .o_chg (w_chg)
  );

  // force_on outranks everything and behaves exactly like a data change.
  assign w_activity = force_on | w_chg;

  always_comb begin
    w_state_next    = r_state;
    w_idle_cnt_next = r_idle_cnt;
    unique case (r_state)
      ACTIVE: begin
        if (w_activity) begin
          w_idle_cnt_next = '0;
        end else if (sleep_req) begin
          w_state_next = DRAIN;
        end else if (r_idle_cnt == LP_CNT_LAST) begin
          w_state_next = DRAIN;
        end else begin
          w_idle_cnt_next = r_idle_cnt + LP_CNT_ONE;
        end
      end
      DRAIN: begin
        if (w_activity) begin
          w_state_next    = ACTIVE;
          w_idle_cnt_next = '0;
        end else begin
          w_state_next = SLEEP;
        end
      end
      SLEEP: begin
        if (w_activity) begin
          w_state_next    = ACTIVE;
          w_idle_cnt_next = '0;
        end
      end
      default: begin
        w_state_next    = ACTIVE;
        w_idle_cnt_next = '0;
      end
    endcase
  end

  // Only a wake from SLEEP pulses; a DRAIN abort never stopped the clock.
  assign w_wake_next = (r_state == SLEEP) && (w_state_next == ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ACTIVE;
      r_idle_cnt   <= '0;
      r_gate_en    <= 1'b1;
      r_awake      <= 1'b1;
      r_wake_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idle_cnt   <= w_idle_cnt_next;
      r_gate_en    <= cg_clock_on(w_state_next);
      r_awake      <= cg_clock_on(w_state_next);
      r_wake_pulse <= w_wake_next;
    end
  end

  assign gate_en    = r_gate_en;
  assign awake      = r_awake;
  assign wake_pulse = r_wake_pulse;
  assign idle_cnt   = r_idle_cnt;

endmodule
